wb_dbg_demux: RTL and testbench

- Sits between the Caravel Wishbone slave port and N subservient debug ports; replaces the direct fan-out that tied every core's o_wb_dbg_rdt/o_wb_dbg_ack onto one bus.
- Decodes address bits into a target core, forwards one transaction at a time, and muxes exactly one response back.
- Also holds a small local register bank (per-core reset, per-core debug_mode, error status) and a timeout so a hung core cannot stall the bus.

---
 rtl/wb_dbg_demux.sv | 181 ++++++++++++++++++
 tb/tb_wb_dbg_demux.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dbg_demux.sv
// Wishbone debug demultiplexer: routes one Caravel WB transaction at a time to a
// subservient debug port, local register bank, or error response. Optional
// broadcast writes to all cores when WB_DBG_BROADCAST_EN is defined.
//
// state  | meaning
// IDLE   | waiting for cyc&stb, decodes target
// FWD    | strobe held on target core(s), waiting for ack / timeout / abort
// RESP   | one-cycle ack back to the Wishbone master
module wb_dbg_demux #(
  parameter int NUM_CORES = 2,
  parameter int SEL_LSB   = 24,
  parameter int TIMEOUT   = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [31:0]               i_wbs_adr,
  input  logic [31:0]               i_wbs_dat,
  input  logic [3:0]                i_wbs_sel,
  input  logic                      i_wbs_we,
  input  logic                      i_wbs_stb,
  input  logic                      i_wbs_cyc,
  output logic [31:0]               o_wbs_rdt,
  output logic                      o_wbs_ack,
  output logic [31:0]               o_dbg_adr,
  output logic [31:0]               o_dbg_dat,
  output logic [3:0]                o_dbg_sel,
  output logic                      o_dbg_we,
  output logic [NUM_CORES-1:0]      o_dbg_stb,
  input  logic [32*NUM_CORES-1:0]   i_dbg_rdt,
  input  logic [NUM_CORES-1:0]      i_dbg_ack,
  output logic [NUM_CORES-1:0]      o_core_rst,
  output logic [NUM_CORES-1:0]      o_debug_mode
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_FWD   = 2'd1;
  localparam logic [1:0]  S_RESP  = 2'd2;
  localparam logic [4:0]  NC      = 5'(NUM_CORES);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] BAD     = 32'hDEAD_BEEF;

  logic [1:0]           state;
  logic [3:0]           tgt;
  logic [15:0]          cnt;
  logic [NUM_CORES-1:0] ctrl_rst, ctrl_dbg;
  logic                 st_err;
  logic [3:0]           st_tgt;

  logic [3:0]           t_in, set_tgt;
  logic                 req, is_core, is_local, is_bcast, fwd_go, req_err;
  logic                 done, fwd_to, st_set, st_clr, loc_wr;
  logic [NUM_CORES-1:0] fwd_mask, stb_left;
  logic [31:0]          loc_rd, ctrl_rd, core_rdt;

  assign t_in     = i_wbs_adr[SEL_LSB+3:SEL_LSB];
  assign is_core  = {1'b0, t_in} < NC;
  assign is_local = (t_in == 4'hF);
`ifdef WB_DBG_BROADCAST_EN
  assign is_bcast = (t_in == 4'hE);
`else
  assign is_bcast = 1'b0;
`endif
  assign req      = (state == S_IDLE) && i_wbs_cyc && i_wbs_stb;
  // broadcast reads are never forwarded; they take the error path
  assign fwd_go   = is_core || (is_bcast && i_wbs_we);
  assign fwd_mask = is_bcast ? '1 : (NUM_CORES'(1) << t_in);
  assign req_err  = req && !is_local && !fwd_go;

  // unicast: stb_left empties on the target's ack; broadcast: on the last ack
  assign stb_left = o_dbg_stb & ~i_dbg_ack;
  assign done     = (stb_left == '0);
  assign fwd_to   = (state == S_FWD) && i_wbs_cyc && !done && (cnt == TO_LAST);

  assign st_set   = req_err || fwd_to;
  assign set_tgt  = fwd_to ? tgt : t_in;
  assign loc_wr   = req && is_local && i_wbs_we;
  assign st_clr   = loc_wr && (i_wbs_adr[3:2] == 2'd1) && i_wbs_sel[0] && i_wbs_dat[0];

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[NUM_CORES-1:0] = ctrl_rst;
    ctrl_rd[8 +: NUM_CORES] = ctrl_dbg;
    loc_rd = '0;
    case (i_wbs_adr[3:2])
      2'd0:    loc_rd = ctrl_rd;
      2'd1:    loc_rd = {20'h0, st_tgt, 7'h0, st_err};
      2'd2:    loc_rd = {24'h5EB000, 8'(NUM_CORES)};
      default: loc_rd = '0;
    endcase
  end

  always_comb begin
    core_rdt = '0;
    for (int k = 0; k < NUM_CORES; k++)
      if (tgt == 4'(k)) core_rdt = i_dbg_rdt[32*k +: 32];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      tgt       <= '0;
      cnt       <= '0;
      o_wbs_ack <= 1'b0;
      o_wbs_rdt <= '0;
      o_dbg_stb <= '0;
      o_dbg_adr <= '0;
      o_dbg_dat <= '0;
      o_dbg_sel <= '0;
      o_dbg_we  <= 1'b0;
    end else begin
      o_wbs_ack <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          o_dbg_adr <= i_wbs_adr;
          o_dbg_dat <= i_wbs_dat;
          o_dbg_sel <= i_wbs_sel;
          o_dbg_we  <= i_wbs_we;
          tgt       <= t_in;
          cnt       <= '0;
          if (fwd_go) begin
            state     <= S_FWD;
            o_dbg_stb <= fwd_mask;
          end else begin
            state     <= S_RESP;
            o_wbs_ack <= 1'b1;
            o_wbs_rdt <= is_local ? loc_rd : BAD;
          end
        end
        S_FWD: begin
          if (!i_wbs_cyc) begin
            o_dbg_stb <= '0;
            cnt       <= '0;
            state     <= S_IDLE;
          end else if (done) begin
            o_dbg_stb <= '0;
            o_wbs_rdt <= core_rdt;
            o_wbs_ack <= 1'b1;
            state     <= S_RESP;
          end else if (cnt == TO_LAST) begin
            o_dbg_stb <= '0;
            o_wbs_rdt <= BAD;
            o_wbs_ack <= 1'b1;
            state     <= S_RESP;
          end else begin
            o_dbg_stb <= stb_left;
            cnt       <= cnt + 16'd1;
          end
        end
        S_RESP: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_rst <= '1;
      ctrl_dbg <= '1;
      st_err   <= 1'b0;
      st_tgt   <= '0;
    end else begin
      if (loc_wr && (i_wbs_adr[3:2] == 2'd0)) begin
        if (i_wbs_sel[0]) ctrl_rst <= i_wbs_dat[NUM_CORES-1:0];
        if (i_wbs_sel[1]) ctrl_dbg <= i_wbs_dat[8 +: NUM_CORES];
      end
      if (st_set) begin
        st_err <= 1'b1;
        st_tgt <= set_tgt;
      end else if (st_clr) begin
        st_err <= 1'b0;
      end
    end
  end

  assign o_core_rst   = ctrl_rst;
  assign o_debug_mode = ctrl_dbg;

endmodule

// File: tb/tb_wb_dbg_demux.sv
// Scoreboard bench for wb_dbg_demux: expected responses are queued at issue time
// and a monitor pops and compares them whenever o_wbs_ack is seen.
module tb_wb_dbg_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, stb, cyc;
  logic [31:0] wbs_rdt, dbg_adr, dbg_dat;
  logic        wbs_ack, dbg_we;
  logic [3:0]  dbg_sel;
  logic [1:0]  dbg_stb, dbg_ack, ack_model, ack_force, core_rst, debug_mode;
  logic [31:0] rdt_core0, rdt_core1;
  logic [63:0] dbg_rdt;

  assign dbg_rdt = {rdt_core1, rdt_core0};
  assign dbg_ack = ack_model | ack_force;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int dly[2];
  bit never[2];
  int ccnt[2];
  int stb_cnt[2];

  typedef struct {
    logic [31:0] rdt;
    bit          chk_rdt;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  wb_dbg_demux dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wbs_adr(adr), .i_wbs_dat(dat), .i_wbs_sel(sel), .i_wbs_we(we),
    .i_wbs_stb(stb), .i_wbs_cyc(cyc),
    .o_wbs_rdt(wbs_rdt), .o_wbs_ack(wbs_ack),
    .o_dbg_adr(dbg_adr), .o_dbg_dat(dbg_dat), .o_dbg_sel(dbg_sel), .o_dbg_we(dbg_we),
    .o_dbg_stb(dbg_stb), .i_dbg_rdt(dbg_rdt), .i_dbg_ack(dbg_ack),
    .o_core_rst(core_rst), .o_debug_mode(debug_mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // issue one transaction at #1 after a posedge; lat = cycles until o_wbs_ack
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit w, input int lat, input bit chk_rdt, input logic [31:0] exp_rdt);
    exp_t e;
    bit   got;
    e.rdt = exp_rdt;
    e.chk_rdt = chk_rdt;
    e.cyc = cyc_n + lat;
    exp_q.push_back(e);
    adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = wbs_ack;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout adr=%h: no ack within 2000 cycles", a);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    adr = '0; dat = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
    ack_model = '0; ack_force = '0;
    rdt_core0 = 32'hA5A5_0000; rdt_core1 = 32'h1234_5678;
    dly = '{0, 0}; never = '{0, 0}; ccnt = '{0, 0}; stb_cnt = '{0, 0};
    rst_n = 1'b0;

    fork
      // core responder model
      forever begin
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
          if (dbg_stb[k] && rst_n) begin
            ack_model[k] = !never[k] && (ccnt[k] == dly[k]);
            ccnt[k]++;
          end else begin
            ack_model[k] = 1'b0;
            ccnt[k] = 0;
          end
        end
      end
      // response monitor
      forever begin
        @(negedge clk);
        if (rst_n) begin
          for (int k = 0; k < 2; k++) stb_cnt[k] += int'(dbg_stb[k]);
          if (wbs_ack) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_ack: got ack rdt=%h at cycle %0d, required no ack", wbs_rdt, cyc_n);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              if (e.chk_rdt) check("ack_rdt", wbs_rdt, e.rdt);
              check("ack_cycle", 32'(cyc_n), 32'(e.cyc));
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk); #1;
    check("rst_ack", 32'(wbs_ack), 32'h0);
    check("rst_rdt", wbs_rdt, 32'h0);
    check("rst_stb", 32'(dbg_stb), 32'h0);
    check("rst_core_rst", 32'(core_rst), 32'h3);
    check("rst_debug_mode", 32'(debug_mode), 32'h3);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // local registers
    xfer(32'h3F00_0000, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0303);
    xfer(32'h3F00_0008, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h5EB0_0002);
    xfer(32'h3F00_0000, 32'h0000_0100, 4'b0011, 1'b1, 1, 1'b0, 32'h0);
    check("ctrl_core_rst", 32'(core_rst), 32'h0);
    check("ctrl_debug_mode", 32'(debug_mode), 32'h1);
    xfer(32'h3F00_0000, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0100);
    xfer(32'h3F00_0000, 32'hFFFF_0203, 4'b0010, 1'b1, 1, 1'b0, 32'h0);
    check("sel_byte1_debug_mode", 32'(debug_mode), 32'h2);
    check("sel_byte1_core_rst", 32'(core_rst), 32'h0);
    xfer(32'h3F00_0000, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0200);
    xfer(32'h3F00_000C, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0);

    // core 1 read, ack 3 cycles after strobe
    dly[1] = 3; stb_cnt = '{0, 0};
    xfer(32'h3100_0040, 32'h0, 4'hF, 1'b0, 5, 1'b1, 32'h1234_5678);
    check("core1_stb_cycles", 32'(stb_cnt[1]), 32'd4);
    check("core1_stb0_idle", 32'(stb_cnt[0]), 32'd0);
    check("core1_dbg_adr", dbg_adr, 32'h3100_0040);

    // core 0 write, immediate ack
    dly[0] = 0; stb_cnt = '{0, 0};
    xfer(32'h3000_0010, 32'hCAFE_0001, 4'b1010, 1'b1, 2, 1'b0, 32'h0);
    check("core0_stb_cycles", 32'(stb_cnt[0]), 32'd1);
    check("core0_stb1_idle", 32'(stb_cnt[1]), 32'd0);
    check("core0_dbg_dat", dbg_dat, 32'hCAFE_0001);
    check("core0_dbg_sel", 32'(dbg_sel), 32'hA);
    check("core0_dbg_we", 32'(dbg_we), 32'h1);

    // timeout on a silent core
    never[0] = 1'b1; stb_cnt = '{0, 0};
    xfer(32'h3000_0000, 32'h0, 4'hF, 1'b0, 256, 1'b1, 32'hDEAD_BEEF);
    check("timeout_stb_cycles", 32'(stb_cnt[0]), 32'd255);
    never[0] = 1'b0;
    xfer(32'h3F00_0004, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0001);
    xfer(32'h3F00_0004, 32'h1, 4'b0001, 1'b1, 1, 1'b0, 32'h0);
    xfer(32'h3F00_0004, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0000);

    // invalid targets
    xfer(32'h3500_0000, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'hDEAD_BEEF);
    xfer(32'h3F00_0004, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0501);
    xfer(32'h3700_0000, 32'h5555_5555, 4'hF, 1'b1, 1, 1'b0, 32'h0);
    xfer(32'h3F00_0004, 32'h1, 4'b0001, 1'b1, 1, 1'b0, 32'h0);
    xfer(32'h3F00_0004, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0700);

`ifdef WB_DBG_BROADCAST_EN
    dly[0] = 1; dly[1] = 4; stb_cnt = '{0, 0};
    xfer(32'h3E00_0000, 32'h1, 4'hF, 1'b1, 6, 1'b0, 32'h0);
    check("bcast_stb0_cycles", 32'(stb_cnt[0]), 32'd2);
    check("bcast_stb1_cycles", 32'(stb_cnt[1]), 32'd5);
    xfer(32'h3F00_0004, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0700);
    dly = '{0, 0};
`endif
    xfer(32'h3E00_0000, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'hDEAD_BEEF);
    xfer(32'h3F00_0004, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0E01);
    xfer(32'h3F00_0004, 32'h1, 4'b0001, 1'b1, 1, 1'b0, 32'h0);
    xfer(32'h3F00_0004, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0E00);

    // master abort 5 cycles into FWD, then a stray late ack
    never[0] = 1'b1; stb_cnt = '{0, 0};
    adr = 32'h3000_0000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("abort_stb_up", 32'(dbg_stb), 32'h1);
    repeat (4) @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("abort_stb_drop", 32'(dbg_stb), 32'h0);
    ack_force = 2'b01;
    @(posedge clk); #1;
    ack_force = 2'b00;
    repeat (5) @(posedge clk); #1;
    check("abort_stb_cycles", 32'(stb_cnt[0]), 32'd5);
    never[0] = 1'b0;
    xfer(32'h3F00_0008, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h5EB0_0002);

    // async reset in the middle of FWD
    never[1] = 1'b1;
    adr = 32'h3100_0000; dat = 32'h0F0F_0F0F; sel = 4'h3; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    repeat (3) @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(wbs_ack), 32'h0);
    check("midrst_rdt", wbs_rdt, 32'h0);
    check("midrst_stb", 32'(dbg_stb), 32'h0);
    check("midrst_dbg_adr", dbg_adr, 32'h0);
    check("midrst_dbg_dat", dbg_dat, 32'h0);
    check("midrst_dbg_sel_we", {27'h0, dbg_sel, dbg_we}, 32'h0);
    check("midrst_core_rst", 32'(core_rst), 32'h3);
    check("midrst_debug_mode", 32'(debug_mode), 32'h3);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    never[1] = 1'b0;
    @(posedge clk); #1;
    xfer(32'h3F00_0004, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0000);
    xfer(32'h3F00_0000, 32'h0, 4'hF, 1'b0, 1, 1'b1, 32'h0000_0303);

    repeat (3) @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
